// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, credit-based arbiter sharing one FIFO write port among N_REQ requesters.
// Define FIFO_ARB_BURST_EN to keep a requester locked until its i_req_last beat.
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*WIDTH-1:0]     i_req_data,
  input  logic [N_REQ-1:0]           i_req_last,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_wr_en,
  output logic [WIDTH-1:0]           o_wr_data,
  input  logic                       i_rd_pulse,
  output logic [$clog2(DEPTH+1)-1:0] o_credits,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = $clog2(N_REQ);
  typedef enum logic {ARB, LOCK} state_t;
  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_credits, w_credits_nxt;
  logic             r_wr_en, r_err;
  logic [WIDTH-1:0] r_wr_data;
  logic [GW-1:0]    r_grant_id, w_sel, w_idx;
  logic [N_REQ-1:0] w_cand, w_ready;
  logic             w_hit, w_xfer, w_ovf;
`ifndef FIFO_ARB_BURST_EN
  logic w_unused;
  assign w_unused = ^i_req_last;
`endif
  // In LOCK the last granted requester is the locked one, so it is the only candidate.
  always_comb begin
    w_cand = (r_state == LOCK) ? (i_req_valid & ({{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id)) : i_req_valid;
    w_hit  = 1'b0;
    w_sel  = r_grant_id;
    w_idx  = r_grant_id;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = GW'((int'(r_grant_id) + k) % N_REQ);
      if (!w_hit && w_cand[w_idx]) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
    w_ready       = (w_hit && r_credits != '0 && rst_n) ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;
    w_xfer        = |w_ready;
    w_ovf         = i_rd_pulse && !w_xfer && r_credits == CW'(DEPTH);
    w_credits_nxt = w_ovf ? r_credits : r_credits - CW'(w_xfer) + CW'(i_rd_pulse);
`ifdef FIFO_ARB_BURST_EN
    w_state_nxt   = !w_xfer ? r_state : (i_req_last[w_sel] ? ARB : LOCK);
`else
    w_state_nxt   = ARB;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_credits  <= CW'(DEPTH);
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_grant_id <= GW'(N_REQ-1);
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_credits <= w_credits_nxt;
      r_wr_en   <= w_xfer;
      r_err     <= r_err | w_ovf;
      if (w_xfer) begin
        r_wr_data  <= i_req_data[w_sel*WIDTH +: WIDTH];
        r_grant_id <= w_sel;
      end
    end
  end
  assign o_req_ready = w_ready;
  assign o_wr_en     = r_wr_en;
  assign o_wr_data   = r_wr_data;
  assign o_credits   = r_credits;
  assign o_grant_id  = r_grant_id;
  assign o_err       = r_err;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port among `N_REQ` requesters. Each requester has a valid/ready handshake. The arbiter keeps its own free-slot credit counter, so it never relies on the FIFO's registered (one-cycle-late) `o_full` flag and never issues a write the FIFO would drop. It sits between producer blocks and the shared FIFO: `o_wr_en`/`o_wr_data` drive the FIFO write side, and the FIFO's `o_ready_pulse` returns credits.

## Interface
- `N_REQ`, 4 — number of requesters; must be ≥ 2.
- `WIDTH`, 8 — data width; must equal the FIFO `WIDTH`.
- `DEPTH`, 64 — FIFO depth; initial credit count.
- `clk`  in  1 — clock; all logic on rising edge.
- `rst_n`  in  1 — reset, asynchronous, active-low.
- `i_req_valid`  in  N_REQ — per-requester data valid.
- `i_req_data`  in  N_REQ*WIDTH — requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `i_req_last`  in  N_REQ — last beat of a burst; used only with `FIFO_ARB_BURST_EN`.
- `o_req_ready`  out  N_REQ — one-hot or zero grant; combinational from `i_req_valid` and registered state.
- `o_wr_en`  out  1 — FIFO write enable; registered.
- `o_wr_data`  out  WIDTH — FIFO write data; registered.
- `i_rd_pulse`  in  1 — FIFO `o_ready_pulse`; one credit returned per cycle it is high.
- `o_credits`  out  $clog2(DEPTH+1) — current free-slot count; registered.
- `o_grant_id`  out  $clog2(N_REQ) — index of the last accepted requester; registered.
- `o_err`  out  1 — sticky credit-overflow error flag.

## Operation
- **Transfer:** requester i transfers in a cycle where `i_req_valid[i] && o_req_ready[i]`. At most one transfer occurs per cycle.
- **Grant eligibility:** a grant is issued only when `o_credits != 0`.
  - Credits returned by `i_rd_pulse` in the same cycle do not make a grant eligible; the credit becomes usable on the next cycle.
- **Round-robin:** search starts at `(o_grant_id + 1) mod N_REQ` and wraps. The first requester with valid set wins.
  - After reset the pointer behaves as if `o_grant_id = N_REQ-1`, so requester 0 has top priority.
- **Credit update (every cycle):** `credits_next = credits - xfer + i_rd_pulse`.
  - Simultaneous transfer and pulse leaves credits unchanged.
  - If `i_rd_pulse` arrives while `credits == DEPTH` and there is no transfer, credits saturate at `DEPTH` and `o_err` sets. `o_err` clears only on reset.
- **Write output:** on a transfer, next cycle `o_wr_en = 1`, `o_wr_data` = the granted requester's data, and `o_grant_id` = i. With no transfer, next cycle `o_wr_en = 0` and `o_wr_data` holds its value.
- **States:** `ARB` (re-arbitrate every beat) and `LOCK` (burst only; see Configuration).
- **Reset values:**
  - `o_wr_en` = 0
  - `o_wr_data` = 0
  - `o_credits` = DEPTH
  - `o_grant_id` = N_REQ-1
  - `o_err` = 0
  - state = `ARB`
  - `o_req_ready` = 0 while `rst_n` is low

## Timing
- Latency from requester transfer to FIFO write: 1 cycle.
- Sustained throughput: 1 beat/cycle while credits > 0.
- Dropping `i_req_valid` without a transfer is legal; no grant is held in `ARB`.
- **Full boundary:** after DEPTH transfers with no reads, `o_credits = 0` and all ready lines are low until a credit returns. The first grant comes the cycle after the pulse.
- **Reset mid-operation:** a pending `o_wr_en` is cleared immediately (asynchronous). The FIFO must be reset together with this block; credits return to DEPTH.

## Configuration
- Macro: `FIFO_ARB_BURST_EN`.
- **Defined:** a transfer with `i_req_last[i] = 0` moves the FSM `ARB` → `LOCK`. In `LOCK`, only the locked requester can be granted; other requesters are masked even if valid. A transfer with `i_req_last = 1` returns the FSM to `ARB`. A zero-credit stall keeps the FSM in `LOCK`. Beats of a burst are contiguous in the FIFO.
- **Undefined:** `i_req_last` is ignored, the FSM stays in `ARB`, and beats from different requesters interleave.

## Test plan
- Reset, all requesters valid with data i+1 each -> grants in order 0,1,2,3,0; `o_wr_data` sequence 1,2,3,4,1; `o_wr_en` high every cycle from cycle 1.
- Only requester 2 valid for 70 cycles, no `i_rd_pulse` -> 64 writes, `o_credits` 0, ready low from the 65th cycle, no `o_wr_en` beyond 64.
- At `o_credits = 0`, assert `i_rd_pulse` 1 cycle -> `o_credits` 1 next cycle, exactly one grant the cycle after, credits back to 0.
- Transfer and `i_rd_pulse` in the same cycle at `o_credits = 10` -> `o_credits` stays 10.
- `i_rd_pulse` at `o_credits = 64` -> `o_credits` stays 64, `o_err` = 1 and stays 1 until `rst_n` low.
- With `FIFO_ARB_BURST_EN`: requester 1 sends a 3-beat burst (last on beat 3) while requester 0 is valid -> FIFO order 1,1,1 then 0; without the macro -> 1,0,1,0 interleaving.
